// File: rtl/heater_pkg.sv
// Shared state codes, command/status field layout and helpers for the heater sequencer.
package heater_pkg;

  localparam logic [2:0] STATE_IDLE      = 3'd0;
  localparam logic [2:0] STATE_RAMP_UP   = 3'd1;
  localparam logic [2:0] STATE_RUN       = 3'd2;
  localparam logic [2:0] STATE_RAMP_DOWN = 3'd3;
  localparam logic [2:0] STATE_DONE      = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = STATE_IDLE,
    ST_RAMP_UP   = STATE_RAMP_UP,
    ST_RUN       = STATE_RUN,
    ST_RAMP_DOWN = STATE_RAMP_DOWN,
    ST_DONE      = STATE_DONE
  } heater_state_t;

  localparam int CMD_RUN_BIT    = 0;
  localparam int CMD_TARGET_LSB = 4;
  localparam int CMD_TARGET_W   = 4;
  localparam int CMD_DUTY_LSB   = 8;
  localparam int CMD_DUTY_W     = 8;
  localparam int CMD_DUR_LSB    = 16;
  localparam int CMD_DUR_W      = 16;

  localparam int STS_STATE_LSB   = 0;
  localparam int STS_STATE_W     = 3;
  localparam int STS_FAULT_BIT   = 3;
  localparam int STS_ACTIVE_LSB  = 4;
  localparam int STS_ACTIVE_W    = 4;
  localparam int STS_ELAPSED_LSB = 16;
  localparam int STS_ELAPSED_W   = 16;

  // Bank counts fit the 4-bit target field, which is why NUM_BANKS tops out at 15.
  localparam int BANK_CNT_W = 4;

  function automatic logic [BANK_CNT_W-1:0] clamp_target(
    input logic [BANK_CNT_W-1:0] req,
    input int                    max_banks
  );
    if (int'(req) > max_banks) return BANK_CNT_W'(max_banks);
    return req;
  endfunction

endpackage

// File: rtl/heater_pwm.sv
// Free-running PWM counter with duty compare; held at zero while disabled.
// wrap pulses on the cycle whose clock edge takes the counter from all-ones back to zero.
module heater_pwm #(
  parameter int PWM_BITS = 8
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_on,
  output logic                wrap
);

  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pwm_cnt <= '0;
    end else if (!enable) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // All-ones duty means fully on rather than on for 2^N-1 of 2^N cycles.
  assign pwm_on = (&duty) || (pwm_cnt < duty);
  assign wrap   = enable && (&pwm_cnt);

endmodule

// File: rtl/heater_sequencer.sv
// Staggered heater-bank sequencer: command register in, PWM-gated bank enables and status out; bank_en lags state by one cycle.
// HEATER_THERMO_LIMIT_EN adds over_temp, which forces a ramp-down and latches a fault that blocks starts until reset.
module heater_sequencer
  import heater_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int NUM_BANKS      = 8,
  parameter int STAGGER_CYCLES = 16,
  parameter int PWM_BITS       = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [BUS_WIDTH-1:0] cmd_reg,
  output logic [BUS_WIDTH-1:0] status_reg,
  output logic [NUM_BANKS-1:0] bank_en
`ifdef HEATER_THERMO_LIMIT_EN
  ,
  input  logic                 over_temp
`endif
);

  localparam int STG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGGER_CYCLES - 1);

  heater_state_t           state;
  logic [BANK_CNT_W-1:0]   active_banks;
  logic [BANK_CNT_W-1:0]   active_inc;
  logic [BANK_CNT_W-1:0]   target_l;
  logic [STG_W-1:0]        stagger_cnt;
  logic [CMD_DUTY_W-1:0]   duty_l;
  logic [CMD_DUR_W-1:0]    duration_l;
  logic [STS_ELAPSED_W-1:0] elapsed;
  logic                    done_flag;
  logic                    fault;
  logic                    trip;

  logic                    run;
  logic [CMD_TARGET_W-1:0] cmd_target;
  logic [CMD_DUTY_W-1:0]   cmd_duty;
  logic [CMD_DUR_W-1:0]    cmd_duration;
  logic                    unused_cmd;

  logic                    pwm_en;
  logic                    pwm_on;
  logic                    pwm_wrap;
  logic [NUM_BANKS-1:0]    bank_mask;

  assign run          = cmd_reg[CMD_RUN_BIT];
  assign cmd_target   = cmd_reg[CMD_TARGET_LSB +: CMD_TARGET_W];
  assign cmd_duty     = cmd_reg[CMD_DUTY_LSB +: CMD_DUTY_W];
  assign cmd_duration = cmd_reg[CMD_DUR_LSB +: CMD_DUR_W];
  assign unused_cmd   = ^cmd_reg[CMD_TARGET_LSB-1:CMD_RUN_BIT+1];

`ifdef HEATER_THERMO_LIMIT_EN
  assign trip = over_temp;
`else
  assign trip = 1'b0;
`endif

  assign active_inc = active_banks + 1'b1;
  assign pwm_en     = (state != ST_IDLE);

  heater_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .enable (pwm_en),
    .duty   (PWM_BITS'(duty_l)),
    .pwm_on (pwm_on),
    .wrap   (pwm_wrap)
  );

  // Lowest-numbered banks fill first so a partial ramp is always a contiguous block.
  always_comb begin
    bank_mask = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      bank_mask[k] = pwm_on && (k < int'(active_banks));
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state        <= ST_IDLE;
      active_banks <= '0;
      target_l     <= '0;
      stagger_cnt  <= '0;
      duty_l       <= '0;
      duration_l   <= '0;
      elapsed      <= '0;
      done_flag    <= 1'b0;
      fault        <= 1'b0;
      bank_en      <= '0;
    end else begin
      bank_en <= bank_mask;
      case (state)
        ST_IDLE: begin
          if (run && (cmd_target != '0) && !fault) begin
            target_l    <= clamp_target(cmd_target, NUM_BANKS);
            duty_l      <= cmd_duty;
            duration_l  <= cmd_duration;
            elapsed     <= '0;
            stagger_cnt <= '0;
            done_flag   <= 1'b0;
            state       <= ST_RAMP_UP;
          end
        end

        ST_RAMP_UP: begin
          if (trip || !run) begin
            fault       <= fault | trip;
            stagger_cnt <= '0;
            state       <= ST_RAMP_DOWN;
          end else if (stagger_cnt == STG_LAST) begin
            stagger_cnt  <= '0;
            active_banks <= active_inc;
            if (active_inc == target_l) state <= ST_RUN;
          end else begin
            stagger_cnt <= stagger_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          if (pwm_wrap && (elapsed != '1)) elapsed <= elapsed + 1'b1;
          // An abort or trip takes precedence over timing out, so it never ends in DONE.
          if (trip || !run) begin
            fault       <= fault | trip;
            stagger_cnt <= '0;
            state       <= ST_RAMP_DOWN;
          end else if ((duration_l != '0) && (elapsed == duration_l)) begin
            done_flag   <= 1'b1;
            stagger_cnt <= '0;
            state       <= ST_RAMP_DOWN;
          end
        end

        ST_RAMP_DOWN: begin
          if (active_banks == '0) begin
            state <= done_flag ? ST_DONE : ST_IDLE;
          end else if (stagger_cnt == STG_LAST) begin
            stagger_cnt  <= '0;
            active_banks <= active_banks - 1'b1;
            if (active_banks == BANK_CNT_W'(1)) state <= done_flag ? ST_DONE : ST_IDLE;
          end else begin
            stagger_cnt <= stagger_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          if (!run) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    status_reg = '0;
    status_reg[STS_STATE_LSB +: STS_STATE_W]     = state;
    status_reg[STS_FAULT_BIT]                    = fault;
    status_reg[STS_ACTIVE_LSB +: STS_ACTIVE_W]   = active_banks;
    status_reg[STS_ELAPSED_LSB +: STS_ELAPSED_W] = elapsed;
  end

endmodule

// File: tb/tb_heater_sequencer.sv
// Bench for heater_sequencer: hand vectors, corner-case sequences, and random commands against a timeline model.
module tb_heater_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] cmd_reg;
  logic [31:0] status_reg;
  logic [7:0]  bank_en;
  logic        over_temp;

  int errors = 0;
  int checks = 0;

`ifdef HEATER_THERMO_LIMIT_EN
  localparam bit THERMO = 1'b1;
`else
  localparam bit THERMO = 1'b0;
`endif

  always #5 Clk = ~Clk;

  heater_sequencer dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .cmd_reg   (cmd_reg),
    .status_reg(status_reg),
    .bank_en   (bank_en)
`ifdef HEATER_THERMO_LIMIT_EN
    ,
    .over_temp (over_temp)
`endif
  );

  // Reference model: each phase is described by its entry time, and bank count,
  // PWM phase and elapsed periods are derived from elapsed time with plain arithmetic.
  int       cyc = 0;
  int       m_phase = 0;
  int       m_t0 = 0;
  int       m_base = 0;
  int       m_start = 0;
  int       m_runt0 = 0;
  int       m_T = 0;
  int       m_d = 0;
  int       m_D = 0;
  int       m_elf = 0;
  bit       m_done = 0;
  bit       m_fault = 0;
  logic [7:0] exp_bank = '0;

  function automatic int m_banks(int now);
    int v;
    case (m_phase)
      1: return m_base + (now - m_t0) / 16;
      2: return m_T;
      3: begin
        v = m_base - (now - m_t0) / 16;
        return (v < 0) ? 0 : v;
      end
      default: return 0;
    endcase
  endfunction

  function automatic int m_el(int now);
    int v;
    if (m_phase != 2) return m_elf;
    v = (now - m_start) / 256 - (m_runt0 - m_start) / 256;
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[2:0]   = 3'(m_phase);
    s[3]     = m_fault;
    s[7:4]   = 4'(m_banks(cyc));
    s[31:16] = 16'(m_el(cyc));
    return s;
  endfunction

  task automatic model_step(input logic [31:0] cmd, input bit trip, input bit rstn);
    int now, pre_b, pre_p, tgt;
    bit run;
    cyc++;
    now = cyc;
    if (!rstn) begin
      m_phase = 0; m_base = 0; m_T = 0; m_d = 0; m_D = 0;
      m_elf = 0; m_done = 0; m_fault = 0; exp_bank = '0;
      return;
    end
    pre_b = m_banks(now - 1);
    pre_p = (m_phase == 0) ? 0 : (now - 1 - m_start) % 256;
    exp_bank = '0;
    if ((m_d == 255) || (pre_p < m_d))
      for (int k = 0; k < 8; k++) if (k < pre_b) exp_bank[k] = 1'b1;
    run = cmd[0];
    tgt = int'(cmd[7:4]);
    case (m_phase)
      0: if (run && tgt != 0 && !m_fault) begin
        m_start = now; m_t0 = now; m_base = 0;
        m_T = (tgt > 8) ? 8 : tgt;
        m_d = int'(cmd[15:8]); m_D = int'(cmd[31:16]);
        m_done = 0; m_elf = 0; m_phase = 1;
      end
      1: if (trip || !run) begin
        m_fault = m_fault | trip; m_base = pre_b; m_t0 = now; m_phase = 3;
      end else if (m_banks(now) == m_T) begin
        m_runt0 = now; m_phase = 2;
      end
      2: if (trip || !run) begin
        m_elf = m_el(now); m_fault = m_fault | trip;
        m_base = m_T; m_t0 = now; m_phase = 3;
      end else if (m_D != 0 && m_el(now - 1) == m_D) begin
        m_elf = m_el(now); m_done = 1;
        m_base = m_T; m_t0 = now; m_phase = 3;
      end
      3: if (m_banks(now) == 0) m_phase = m_done ? 4 : 0;
      4: if (!run) m_phase = 0;
      default: m_phase = 0;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge, compare at the next falling edge.
  task automatic step(input logic [31:0] cmd, input bit trip, input bit rstn);
    cmd_reg   = cmd;
    over_temp = trip;
    Reset_n   = rstn;
    @(posedge Clk);
    model_step(cmd, THERMO && trip, rstn);
    @(negedge Clk);
    check("model_status", status_reg, exp_status());
    check("model_bank_en", {24'h0, bank_en}, {24'h0, exp_bank});
  endtask

  task automatic run_n(input logic [31:0] cmd, input int n);
    for (int i = 0; i < n; i++) step(cmd, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [31:0] cmd;
    int          n;
    logic [31:0] st;
    logic [7:0]  be;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int cnt_on, cnt_hi, cnt_bad, seg;
    logic [31:0] rc;
    logic [7:0]  rd;

    // Full ramp and timed run: target 8, duty 0xFF, two periods.
    tbl[0]  = '{32'h0002_FF81,   1, 32'h0000_0001, 8'h00};
    tbl[1]  = '{32'h0002_FF81,  16, 32'h0000_0011, 8'h00};
    tbl[2]  = '{32'h0002_FF81,   1, 32'h0000_0011, 8'h01};
    tbl[3]  = '{32'h0002_FF81, 111, 32'h0000_0082, 8'h7F};
    tbl[4]  = '{32'h0002_FF81,   1, 32'h0000_0082, 8'hFF};
    tbl[5]  = '{32'h0002_FF81, 127, 32'h0001_0082, 8'hFF};
    tbl[6]  = '{32'h0002_FF81, 257, 32'h0002_0083, 8'hFF};
    tbl[7]  = '{32'h0002_FF81,  16, 32'h0002_0073, 8'hFF};
    tbl[8]  = '{32'h0002_FF81,   1, 32'h0002_0073, 8'h7F};
    tbl[9]  = '{32'h0002_FF81, 111, 32'h0002_0004, 8'h01};
    tbl[10] = '{32'h0002_FF81,  50, 32'h0002_0004, 8'h00};
    tbl[11] = '{32'h0000_0000,   1, 32'h0002_0000, 8'h00};

    Reset_n = 1'b0; cmd_reg = '0; over_temp = 1'b0;
    do_reset();
    check("reset_status", status_reg, 32'h0);
    check("reset_bank_en", {24'h0, bank_en}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      run_n(tbl[i].cmd, tbl[i].n);
      check($sformatf("tbl%0d_status", i), status_reg, tbl[i].st);
      check($sformatf("tbl%0d_bank_en", i), {24'h0, bank_en}, {24'h0, tbl[i].be});
    end

    // Reset in the middle of a ramp.
    do_reset();
    run_n(32'h0000_8081, 40);
    step(32'h0000_8081, 1'b0, 1'b0);
    check("midramp_reset_status", status_reg, 32'h0);
    check("midramp_reset_bank_en", {24'h0, bank_en}, 32'h0);

    // PWM duty 0x40 on a single bank, unlimited duration.
    step(32'h0, 1'b0, 1'b0);
    run_n(32'h0000_4011, 20);
    check("duty_run_status", status_reg, 32'h0000_0012);
    for (int w = 0; w < 2; w++) begin
      cnt_on = 0; cnt_hi = 0;
      for (int i = 0; i < 256; i++) begin
        step(32'h0000_4011, 1'b0, 1'b1);
        if (bank_en[0]) cnt_on++;
        if (bank_en[7:1] != 7'h0) cnt_hi++;
      end
      check($sformatf("duty_window%0d_on", w), 32'(cnt_on), 32'd64);
      check($sformatf("duty_window%0d_upper", w), 32'(cnt_hi), 32'd0);
    end

    // Target 15 clamps to 8, then a clean abort returns to IDLE.
    do_reset();
    run_n(32'h0000_F0F1, 129);
    check("clamp_run_status", status_reg, 32'h0000_0082);
    run_n(32'h0000_F0F1, 20);
    check("clamp_hold_status", status_reg, 32'h0000_0082);
    run_n(32'h0000_F0F0, 129);
    check("clamp_abort_idle", status_reg, 32'h0);

    // Abort at three banks, with run re-asserted during the ramp-down.
    do_reset();
    run_n(32'h0000_F0F1, 49);
    check("abort_at3_status", status_reg, 32'h0000_0031);
    run_n(32'h0000_F0F0, 1);
    check("abort_down_status", status_reg, 32'h0000_0033);
    run_n(32'h0000_F0F0, 5);
    run_n(32'h0000_F0F1, 42);
    check("abort_rerun_ignored", status_reg, 32'h0000_0013);
    run_n(32'h0000_F0F1, 1);
    check("abort_end_idle", status_reg, 32'h0);
    run_n(32'h0, 3);

    // Start with target 0 never leaves IDLE.
    do_reset();
    cnt_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step(32'h0001_8001, 1'b0, 1'b1);
      if (status_reg != 32'h0 || bank_en != 8'h0) cnt_bad++;
    end
    check("ignored_start_cycles", 32'(cnt_bad), 32'd0);

`ifdef HEATER_THERMO_LIMIT_EN
    // One-cycle over_temp in RUN latches the fault and blocks restarts until reset.
    do_reset();
    run_n(32'h0000_8081, 140);
    step(32'h0000_8081, 1'b1, 1'b1);
    check("trip_status", status_reg, 32'h0000_008B);
    run_n(32'h0000_8081, 130);
    check("trip_idle_fault", status_reg, 32'h0000_0008);
    run_n(32'h0000_8081, 200);
    check("trip_blocked_status", status_reg, 32'h0000_0008);
    check("trip_blocked_bank_en", {24'h0, bank_en}, 32'h0);
    step(32'h0000_8081, 1'b0, 1'b0);
    check("trip_reset_clears", status_reg, 32'h0);
    step(32'h0000_8081, 1'b0, 1'b1);
    check("trip_restart", status_reg, 32'h0000_0001);
`endif

    // Random command segments, including live field changes and occasional resets.
    do_reset();
    for (int s = 0; s < 30; s++) begin
      rd = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: rd = 8'h00;
        1: rd = 8'hFF;
        default: ;
      endcase
      rc = {16'($urandom_range(0, 3)), rd, 4'($urandom_range(0, 15)), 3'b000,
            1'($urandom_range(0, 9) < 7)};
      seg = $urandom_range(1, 600);
      if ($urandom_range(0, 19) == 0) step(rc, 1'b0, 1'b0);
      for (int i = 0; i < seg; i++)
        step(rc, THERMO && ($urandom_range(0, 299) == 0), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
